// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the parameterised memory controller
//
// Contents:
//   RSP_DATA_MAX - widest data word a response can carry (DATA_W <= this)
//   op_e         - request operation encoding
//   mem_rsp_t    - packed response record carried through pipeline and FIFO
package mem_pkg;

    localparam int RSP_DATA_MAX = 128;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // rdata is sized for the widest legal word; narrower controllers
    // zero-extend into it and use only the low DATA_W bits.
    typedef struct packed {
        logic [RSP_DATA_MAX-1:0] rdata;
        logic                    err;
        logic                    wr;
    } mem_rsp_t;

endpackage

// File: rtl/mem_rsp_fifo.sv
// rtl/mem_rsp_fifo.sv - small synchronous FIFO for response records
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   push, push_data   - enqueue (ignored when full)
//   pop, pop_data     - dequeue; pop_data shows the head (first-word fall-through)
//   full, empty       - occupancy flags
//   count             - number of stored entries
module mem_rsp_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  T                 push_data,
    input  logic             pop,
    output T                 pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    T                 store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = store[rd_ptr];

    // Storage carries no reset; consumers qualify pop_data with empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Depth need not be a power of two, so pointers wrap explicitly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/param_mem_ctrl.sv
// rtl/param_mem_ctrl.sv - word memory with byte-enabled writes, scrub-on-reset and credit-based response flow
//
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   req_valid/req_ready            - request handshake
//   req_op, req_addr               - 1 = write / 0 = read, word address
//   req_wdata, req_be              - write data and byte enables
//   rsp_valid/rsp_ready            - response handshake
//   rsp_rdata, rsp_err, rsp_wr     - read data (0 for writes/errors), range error, write marker
//   init_done                      - high once the post-reset zero scrub has finished
module param_mem_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_wr,
    output logic                init_done
);

    localparam int BE_W   = DATA_W / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FIFO_D = RD_LAT + 1;
    localparam int CRED_W = $clog2(RD_LAT + 2);
    localparam int FCNT_W = $clog2(FIFO_D + 1);

    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(FIFO_D);

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e              state;
    state_e              state_nxt;
    logic                run;
    logic [IDX_W-1:0]    init_idx;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [CRED_W-1:0]   credits;
    logic                acc;
    logic                pop;
    logic                in_range;
    logic                is_wr;
    logic [IDX_W-1:0]    widx;
    mem_rsp_t            acc_rsp;
    mem_rsp_t            push_d;
    mem_rsp_t            head;
    logic                push_v;
    logic                fifo_empty;
    logic                fifo_full_unused;
    logic [FCNT_W-1:0]   fifo_count_unused;
    logic                rdata_hi_unused;

    // ---------------- FSM: state register / next state / outputs ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == S_INIT && init_idx == LAST_IDX) begin
            state_nxt = S_RUN;
        end
    end

    always_comb begin
        run       = (state == S_RUN);
        init_done = run;
    end

    // Scrub pointer: one word per cycle, restarts from 0 on every reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_idx <= '0;
        end else if (state == S_INIT && init_idx != LAST_IDX) begin
            init_idx <= init_idx + 1'b1;
        end
    end

    // ---------------- request side ----------------
    // Credits bound in-flight plus queued responses to the FIFO depth, so a
    // response always has a slot by the time it leaves the pipeline.
    assign req_ready = run && (credits < CRED_MAX);
    assign acc       = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign in_range  = ({1'b0, req_addr} < DEPTH_V);
    assign is_wr     = (op_e'(req_op) == OP_WRITE);
    assign widx      = req_addr[IDX_W-1:0];

    // The array itself is never reset; only the scrub clears it.
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            mem[init_idx] <= '0;
        end else if (acc && is_wr && in_range) begin
            for (int b = 0; b < BE_W; b++) begin
                if (req_be[b]) begin
                    mem[widx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data is taken at the accept edge, so a write accepted one cycle
    // earlier is already in the array.
    always_comb begin
        acc_rsp     = '0;
        acc_rsp.wr  = is_wr;
        acc_rsp.err = !in_range;
        if (!is_wr && in_range) begin
            acc_rsp.rdata = RSP_DATA_MAX'(mem[widx]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= '0;
        end else begin
            case ({acc, pop})
                2'b10:   credits <= credits + 1'b1;
                2'b01:   credits <= credits - 1'b1;
                default: credits <= credits;
            endcase
        end
    end

    // ---------------- latency pipeline ----------------
    // The FIFO write is the last register stage, so RD_LAT-1 stages sit in
    // front of it and a response is visible RD_LAT cycles after accept.
    generate
        if (RD_LAT == 1) begin : g_nopipe
            assign push_v = acc;
            assign push_d = acc_rsp;
        end else begin : g_pipe
            logic     pv [RD_LAT-1];
            mem_rsp_t pd [RD_LAT-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < RD_LAT - 1; k++) begin
                        pv[k] <= 1'b0;
                        pd[k] <= '0;
                    end
                end else begin
                    pv[0] <= acc;
                    pd[0] <= acc_rsp;
                    for (int k = 1; k < RD_LAT - 1; k++) begin
                        pv[k] <= pv[k-1];
                        pd[k] <= pd[k-1];
                    end
                end
            end

            assign push_v = pv[RD_LAT-2];
            assign push_d = pd[RD_LAT-2];
        end
    endgenerate

    mem_rsp_fifo #(
        .DEPTH (FIFO_D),
        .T     (mem_rsp_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_v),
        .push_data (push_d),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full_unused),
        .empty     (fifo_empty),
        .count     (fifo_count_unused)
    );

    // Outputs are gated by empty because FIFO storage is not reset.
    assign rsp_valid       = !fifo_empty;
    assign rsp_rdata       = fifo_empty ? '0 : head.rdata[DATA_W-1:0];
    assign rsp_err         = !fifo_empty && head.err;
    assign rsp_wr          = !fifo_empty && head.wr;
    assign rdata_hi_unused = ^head.rdata;

endmodule
